// File: rtl/io_tx_req_ctrl_if.sv
// L2 read port bundle for the uDMA TX request controller.
// master = controller side, slave = L2 side.
interface io_tx_req_ctrl_if #(
    parameter int L2_AWIDTH  = 19,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic [L2_AWIDTH-1:0]  addr;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/io_tx_req_ctrl.sv
// uDMA TX channel request controller: issues L2 reads paced by the TX CDC FIFO and forwards beats.
// Optional IO_TX_REQ_CTRL_BYTE_ALIGN_EN shifts the addressed byte/halfword lane down to bit 0.
module io_tx_req_ctrl #(
    parameter int L2_AWIDTH       = 19,
    parameter int TRANS_SIZE      = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  src_clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_start_i,
    input  logic [L2_AWIDTH-1:0]  cfg_addr_i,
    input  logic [TRANS_SIZE-1:0] cfg_size_i,
    input  logic [1:0]            cfg_datasize_i,
    input  logic                  cfg_continuous_i,
    input  logic                  cfg_stop_i,
    output logic                  busy_o,
    output logic [L2_AWIDTH-1:0]  curr_addr_o,
    output logic [TRANS_SIZE-1:0] bytes_left_o,
    output logic                  evt_done_o,
    input  logic                  fifo_req_i,
    output logic                  fifo_gnt_o,
    output logic                  fifo_valid_o,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    io_tx_req_ctrl_if.master      mem
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [L2_AWIDTH-1:0]  addr_q, start_addr_q;
    logic [TRANS_SIZE-1:0] left_q, start_size_q;
    logic [1:0]            ds_q, start_ds_q;
    logic [CW-1:0]         out_q;
    logic                  stopped_q;

    logic [TRANS_SIZE-1:0] step_size;
    logic [L2_AWIDTH-1:0]  step_addr;
    logic                  can_req, grant, last_grant, reload;

    function automatic logic [1:0] norm_ds(input logic [1:0] ds);
        return (ds == 2'b11) ? 2'b10 : ds;
    endfunction

    assign step_size  = TRANS_SIZE'(1) << ds_q;
    assign step_addr  = L2_AWIDTH'(1) << ds_q;
    assign can_req    = (state_q == RUN) && (left_q != '0) && (out_q < CW'(MAX_OUTSTANDING));
    assign mem.req    = can_req && fifo_req_i;
    assign mem.addr   = {addr_q[L2_AWIDTH-1:2], 2'b00};
    assign grant      = mem.req && mem.gnt;
    // A tail shorter than the step still costs one full beat.
    assign last_grant = grant && (left_q <= step_size);
    assign reload     = cfg_continuous_i && !stopped_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cfg_start_i) state_d = (cfg_size_i == '0) ? DONE : RUN;
            RUN:   if (last_grant || cfg_stop_i || left_q == '0) state_d = DRAIN;
            DRAIN: if (out_q == '0) state_d = DONE;
            DONE:  state_d = reload ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge src_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            left_q       <= '0;
            ds_q         <= '0;
            start_addr_q <= '0;
            start_size_q <= '0;
            start_ds_q   <= '0;
            out_q        <= '0;
            stopped_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case ({grant, mem.rvalid})
                2'b10:   out_q <= out_q + CW'(1);
                2'b01:   if (out_q != '0) out_q <= out_q - CW'(1);
                default: ;
            endcase
            if (state_q == IDLE && cfg_start_i) begin
                addr_q       <= cfg_addr_i;
                left_q       <= cfg_size_i;
                ds_q         <= norm_ds(cfg_datasize_i);
                start_addr_q <= cfg_addr_i;
                start_size_q <= cfg_size_i;
                start_ds_q   <= norm_ds(cfg_datasize_i);
                stopped_q    <= 1'b0;
            end else if (state_q == DONE && reload) begin
                addr_q <= start_addr_q;
                left_q <= start_size_q;
                ds_q   <= start_ds_q;
            end else if (grant) begin
                addr_q <= addr_q + step_addr;
                left_q <= last_grant ? '0 : left_q - step_size;
            end
            if (state_q == RUN && cfg_stop_i) stopped_q <= 1'b1;
        end
    end

    // busy also covers the single DONE cycle of a continuous reload so it never dips between passes.
    assign busy_o       = (state_q == RUN) || (state_q == DRAIN) || ((state_q == DONE) && reload);
    assign curr_addr_o  = addr_q;
    assign bytes_left_o = left_q;
    assign evt_done_o   = (state_q == DONE) && !stopped_q;
    assign fifo_gnt_o   = grant;
    assign fifo_valid_o = mem.rvalid;

`ifdef IO_TX_REQ_CTRL_BYTE_ALIGN_EN
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [3:0]    q_mem [MAX_OUTSTANDING];
    logic [QW-1:0] wr_q, rd_q;

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
    endfunction

    // Entry = {addr[1:0], datasize}; responses return in order so a plain ring suffices.
    function automatic logic [DATA_WIDTH-1:0] align_data(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [3:0] e);
        case (e[1:0])
            2'b00:   return DATA_WIDTH'(8'(d >> {e[3:2], 3'b000}));
            2'b01:   return DATA_WIDTH'(16'(d >> {e[3], 4'b0000}));
            default: return d;
        endcase
    endfunction

    always_ff @(posedge src_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (grant)      wr_q <= ptr_inc(wr_q);
            if (mem.rvalid) rd_q <= ptr_inc(rd_q);
        end
    end

    always_ff @(posedge src_clk_i) begin
        if (grant) q_mem[wr_q] <= {addr_q[1:0], ds_q};
    end

    assign fifo_data_o = align_data(mem.rdata, q_mem[rd_q]);
`else
    assign fifo_data_o = mem.rdata;
`endif
endmodule

// File: tb/tb_io_tx_req_ctrl.sv
// Directed bench for io_tx_req_ctrl: word/byte transfers, backpressure, continuous, stop, size 0, reset.
module tb_io_tx_req_ctrl;
    localparam int AW = 19;
    localparam int TS = 20;
    localparam int DW = 32;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cfg_start, cfg_continuous, cfg_stop, fifo_req;
    logic [AW-1:0] cfg_addr;
    logic [TS-1:0] cfg_size;
    logic [1:0]    cfg_ds;
    logic          busy, evt_done, fifo_gnt, fifo_valid;
    logic [AW-1:0] curr_addr;
    logic [TS-1:0] bytes_left;
    logic [DW-1:0] fifo_data;
    logic          gnt_en, rsp_en, busy_mon;
    logic [DW-1:0] rdata_v;

    always #5 clk = ~clk;

    io_tx_req_ctrl_if #(.L2_AWIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    io_tx_req_ctrl #(.L2_AWIDTH(AW), .TRANS_SIZE(TS), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .src_clk_i(clk), .rstn_i(rstn),
        .cfg_start_i(cfg_start), .cfg_addr_i(cfg_addr), .cfg_size_i(cfg_size),
        .cfg_datasize_i(cfg_ds), .cfg_continuous_i(cfg_continuous), .cfg_stop_i(cfg_stop),
        .busy_o(busy), .curr_addr_o(curr_addr), .bytes_left_o(bytes_left), .evt_done_o(evt_done),
        .fifo_req_i(fifo_req), .fifo_gnt_o(fifo_gnt), .fifo_valid_o(fifo_valid), .fifo_data_o(fifo_data),
        .mem(mem_if)
    );

    assign mem_if.gnt   = gnt_en;
    assign mem_if.rdata = rdata_v;

    // L2 model: in-order responses one cycle after grant, held off while rsp_en is low.
    int pend;
    always @(posedge clk or negedge rstn) begin
        int p;
        if (!rstn) begin
            pend = 0;
            mem_if.rvalid <= 1'b0;
        end else begin
            p = pend + ((mem_if.req && mem_if.gnt) ? 1 : 0);
            if (rsp_en && p > 0) begin
                mem_if.rvalid <= 1'b1;
                p--;
            end else begin
                mem_if.rvalid <= 1'b0;
            end
            pend = p;
        end
    end

    logic [31:0] alog [64];
    logic [31:0] dlog [64];
    int ngnt = 0, nval = 0, nevt = 0, busy_low = 0;
    always @(negedge clk) begin
        if (fifo_gnt && ngnt < 64) begin alog[ngnt] = 32'(mem_if.addr); ngnt++; end
        if (fifo_valid && nval < 64) begin dlog[nval] = fifo_data; nval++; end
        if (evt_done) nevt++;
        if (busy_mon && !busy) busy_low++;
    end

    int nvec = 0, nerr = 0;
    int g0, v0, e0, b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [AW-1:0] a, input logic [TS-1:0] s, input logic [1:0] d);
        g0 = ngnt; v0 = nval; e0 = nevt; b0 = busy_low;
        cfg_addr = a; cfg_size = s; cfg_ds = d; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; cfg_start = 0; cfg_continuous = 0; cfg_stop = 0; fifo_req = 0;
        cfg_addr = '0; cfg_size = '0; cfg_ds = '0;
        gnt_en = 0; rsp_en = 1; rdata_v = '0; busy_mon = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_curr_addr", 32'(curr_addr), 0);
        chk("rst_bytes_left", 32'(bytes_left), 0);
        chk("rst_evt", 32'(evt_done), 0);
        chk("rst_mem_req", 32'(mem_if.req), 0);
        chk("rst_mem_addr", 32'(mem_if.addr), 0);
        chk("rst_fifo_gnt", 32'(fifo_gnt), 0);
        chk("rst_fifo_valid", 32'(fifo_valid), 0);
        chk("rst_fifo_data", fifo_data, 0);
        rstn = 1'b1;
        tick(1);

        fifo_req = 1; gnt_en = 1;
        start_xfer(19'h0, 20'd0, 2'b10);
        chk("size0_evt", 32'(evt_done), 1);
        chk("size0_req", 32'(mem_if.req), 0);
        tick(1);
        chk("size0_evt_once", 32'(evt_done), 0);
        chk("size0_busy", 32'(busy), 0);
        chk("size0_no_gnt", 32'(ngnt - g0), 0);

        rdata_v = 32'h11223344;
        start_xfer(19'h100, 20'd12, 2'b10);
        tick(10);
        chk("w_grants", 32'(ngnt - g0), 3);
        chk("w_addr0", alog[g0], 32'h100);
        chk("w_addr1", alog[g0+1], 32'h104);
        chk("w_addr2", alog[g0+2], 32'h108);
        chk("w_beats", 32'(nval - v0), 3);
        chk("w_data0", dlog[v0], 32'h11223344);
        chk("w_evt", 32'(nevt - e0), 1);
        chk("w_bytes_left", 32'(bytes_left), 0);
        chk("w_curr_addr", 32'(curr_addr), 32'h10C);
        chk("w_busy", 32'(busy), 0);

        rdata_v = 32'hAABBCCDD;
        start_xfer(19'h3, 20'd2, 2'b00);
        tick(8);
        chk("b_grants", 32'(ngnt - g0), 2);
        chk("b_addr0", alog[g0], 32'h0);
        chk("b_addr1", alog[g0+1], 32'h4);
        chk("b_beats", 32'(nval - v0), 2);
`ifdef IO_TX_REQ_CTRL_BYTE_ALIGN_EN
        chk("b_data0", dlog[v0], 32'h000000AA);
        chk("b_data1", dlog[v0+1], 32'h000000DD);
`else
        chk("b_data0", dlog[v0], 32'hAABBCCDD);
        chk("b_data1", dlog[v0+1], 32'hAABBCCDD);
`endif
        chk("b_curr_addr", 32'(curr_addr), 32'h5);
        chk("b_bytes_left", 32'(bytes_left), 0);
        chk("b_evt", 32'(nevt - e0), 1);

        rsp_en = 0;
        start_xfer(19'h200, 20'd16, 2'b10);
        tick(5);
        chk("bp_two_grants", 32'(ngnt - g0), 2);
        chk("bp_req_blocked", 32'(mem_if.req), 0);
        chk("bp_busy", 32'(busy), 1);
        rsp_en = 1;
        tick(1);
        rsp_en = 0;
        tick(4);
        chk("bp_one_more", 32'(ngnt - g0), 3);
        chk("bp_beats1", 32'(nval - v0), 1);
        chk("bp_req_blocked2", 32'(mem_if.req), 0);
        fifo_req = 0; rsp_en = 1;
        tick(5);
        chk("bp_beats3", 32'(nval - v0), 3);
        chk("bp_fifo_off", 32'(mem_if.req), 0);
        fifo_req = 1;
        #1;
        chk("bp_fifo_on", 32'(mem_if.req), 1);
        fifo_req = 0;
        #1;
        chk("bp_fifo_drop", 32'(mem_if.req), 0);
        fifo_req = 1;
        tick(10);
        chk("bp_grants", 32'(ngnt - g0), 4);
        chk("bp_addr3", alog[g0+3], 32'h20C);
        chk("bp_beats", 32'(nval - v0), 4);
        chk("bp_evt", 32'(nevt - e0), 1);
        chk("bp_busy_end", 32'(busy), 0);

        cfg_continuous = 1;
        start_xfer(19'h40, 20'd4, 2'b10);
        busy_mon = 1;
        for (int i = 0; i < 40; i++) begin
            if (nevt - e0 >= 3) break;
            tick(1);
        end
        chk("c_evt3", 32'(nevt - e0), 3);
        chk("c_grants", 32'(ngnt - g0), 3);
        chk("c_curr_addr", 32'(curr_addr), 32'h40);
        chk("c_busy", 32'(busy), 1);
        chk("c_busy_never_low", 32'(busy_low - b0), 0);
        busy_mon = 0;
        cfg_continuous = 0;
        tick(8);
        chk("c_evt_final", 32'(nevt - e0), 4);
        chk("c_busy_end", 32'(busy), 0);

        rsp_en = 0;
        start_xfer(19'h300, 20'd16, 2'b10);
        tick(1);
        fifo_req = 0; cfg_stop = 1;
        tick(1);
        cfg_stop = 0; fifo_req = 1;
        tick(3);
        chk("s_one_grant", 32'(ngnt - g0), 1);
        chk("s_no_req", 32'(mem_if.req), 0);
        chk("s_busy_drain", 32'(busy), 1);
        chk("s_bytes_left", 32'(bytes_left), 12);
        rsp_en = 1;
        tick(6);
        chk("s_beat", 32'(nval - v0), 1);
        chk("s_busy_end", 32'(busy), 0);
        chk("s_no_evt", 32'(nevt - e0), 0);
        chk("s_grants_end", 32'(ngnt - g0), 1);

        start_xfer(19'h400, 20'd4, 2'b10);
        cfg_stop = 1;
        tick(1);
        cfg_stop = 0;
        tick(6);
        chk("sl_grant", 32'(ngnt - g0), 1);
        chk("sl_beat", 32'(nval - v0), 1);
        chk("sl_no_evt", 32'(nevt - e0), 0);
        chk("sl_bytes_left", 32'(bytes_left), 0);
        chk("sl_busy", 32'(busy), 0);

        start_xfer(19'h500, 20'd64, 2'b10);
        tick(3);
        #2;
        rstn = 1'b0;
        #1;
        chk("r_busy", 32'(busy), 0);
        chk("r_curr_addr", 32'(curr_addr), 0);
        chk("r_bytes_left", 32'(bytes_left), 0);
        chk("r_mem_req", 32'(mem_if.req), 0);
        chk("r_fifo_gnt", 32'(fifo_gnt), 0);
        chk("r_fifo_valid", 32'(fifo_valid), 0);
        chk("r_evt", 32'(evt_done), 0);
        tick(1);
        rstn = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
